// File: rtl/pwm_capture_pkg.sv
// pwm_capture_pkg: shared FSM state type and default counter width for pwm_capture
package pwm_capture_pkg;
  localparam int CNT_W_DEF = 16;
  typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, LOW = 2'd2} state_e;
endpackage

// File: rtl/pwm_capture_if.sv
// pwm_capture_if: capture control input and measurement results
interface pwm_capture_if
  import pwm_capture_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);
  logic ena;
  logic pwm_in;
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] high_cnt;
  logic valid;
  logic stuck_high;
  logic stuck_low;
  modport master(output ena, pwm_in, input period_cnt, high_cnt, valid, stuck_high, stuck_low);
  modport slave(input ena, pwm_in, output period_cnt, high_cnt, valid, stuck_high, stuck_low);
endinterface

// File: rtl/pwm_capture_cond.sv
// pwm_in_cond: 2-flop synchronizer, optional 3-sample majority filter
// (PWM_CAPTURE_GLITCH_FILTER_EN) and registered edge detect for pwm_in.
module pwm_in_cond (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [1:0] sync_q, sync_d;
  logic lvl_q, lvl_d, rise_q, rise_d, fall_q, fall_d, src;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  logic [2:0] filt_q, filt_d;
  always_comb begin
    filt_d = {filt_q[1:0], sync_q[1]};
    src = (filt_q[0] & filt_q[1]) | (filt_q[1] & filt_q[2]) | (filt_q[0] & filt_q[2]);
  end
  always_ff @(posedge clk) filt_q <= rst ? '0 : filt_d;
`else
  assign src = sync_q[1];
`endif
  always_comb begin
    sync_d = {sync_q[0], din};
    lvl_d = src;
    rise_d = src & ~lvl_q;
    fall_d = ~src & lvl_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      lvl_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      lvl_q <= lvl_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end
  assign level = lvl_q;
  assign rise = rise_q;
  assign fall = fall_q;
endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of pwm_in between rising edges,
// flags a stuck input after TIMEOUT edgeless cycles. Filter: PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int unsigned TIMEOUT = 2 ** CNT_W - 1
) (
  input logic clk,
  input logic rst,
  pwm_capture_if.slave bus
);
  localparam logic [CNT_W-1:0] TMO = TIMEOUT[CNT_W-1:0];
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, hcnt_q, hcnt_d, period_q, period_d, high_q, high_d;
  logic valid_q, valid_d, sh_q, sh_d, sl_q, sl_d, level, rise, fall, cnt_sat;
  pwm_in_cond u_cond (
    .clk(clk),
    .rst(rst),
    .din(bus.pwm_in),
    .level(level),
    .rise(rise),
    .fall(fall)
  );
  assign cnt_sat = cnt_q == TMO;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_sat ? cnt_q : cnt_q + 1'b1;
    hcnt_d = hcnt_q;
    period_d = period_q;
    high_d = high_q;
    valid_d = 1'b0;
    sh_d = sh_q;
    sl_d = sl_q;
    if (!bus.ena) begin
      state_d = IDLE;
      cnt_d = '0;
      hcnt_d = '0;
    end else if (rise) begin
      state_d = HIGH;
      cnt_d = CNT_W'(1);
      hcnt_d = CNT_W'(1);
      if (state_q == LOW) begin
        period_d = cnt_q;
        high_d = hcnt_q;
        valid_d = 1'b1;
        sh_d = 1'b0;
        sl_d = 1'b0;
      end
    end else if (fall && state_q != LOW) begin
      state_d = state_q == HIGH ? LOW : IDLE;
      cnt_d = state_q == IDLE ? CNT_W'(1) : cnt_d;
    end else if (cnt_sat && (state_q != IDLE || !(sh_q || sl_q))) begin
      // an idle timeout is reported once; the counter then rests saturated
      state_d = IDLE;
      cnt_d = '0;
      hcnt_d = '0;
      period_d = '0;
      high_d = '0;
      valid_d = 1'b1;
      sh_d = level;
      sl_d = ~level;
    end else if (state_q == HIGH) begin
      hcnt_d = hcnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      hcnt_q <= '0;
      period_q <= '0;
      high_q <= '0;
      valid_q <= 1'b0;
      sh_q <= 1'b0;
      sl_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      hcnt_q <= hcnt_d;
      period_q <= period_d;
      high_q <= high_d;
      valid_q <= valid_d;
      sh_q <= sh_d;
      sl_q <= sl_d;
    end
  end
  assign bus.period_cnt = period_q;
  assign bus.high_cnt = high_q;
  assign bus.valid = valid_q;
  assign bus.stuck_high = sh_q;
  assign bus.stuck_low = sl_q;
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: two pwm_capture instances (short/long timeout) checked every cycle
// against an edge-time model, plus literal expectations for the directed scenarios.
module tb_pwm_capture;
  typedef struct {
    bit armed;
    int p, tf, t0, per, hi;
    bit v, sh, sl;
    bit [7:0] h;
  } mdl_t;
  logic clk = 1'b0, rst = 1'b1, ena = 1'b1, pwm = 1'b0;
  int checks = 0, fails = 0, cyc = 0, va_cnt = 0, vb_cnt = 0, off_v = 0, b_last = 0, b_prev = 0;
  bit started = 1'b0, ena_s = 1'b1;
  mdl_t ma, mb;
  always #5 clk = ~clk;
  pwm_capture_if #(.CNT_W(10)) ifa ();
  pwm_capture_if #(.CNT_W(16)) ifb ();
  assign ifa.ena = ena;
  assign ifa.pwm_in = pwm;
  assign ifb.ena = ena;
  assign ifb.pwm_in = pwm;
  pwm_capture #(.CNT_W(10), .TIMEOUT(100)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  pwm_capture dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  function automatic bit maj(bit a, bit b, bit c);
    return (a & b) | (b & c) | (a & c);
  endfunction
`endif
  // h[i] is the raw input sampled i+1 edges ago; the capture logic sees it 3 edges late
  // (5 with the filter). Periods are differences of rising-edge times n, high time is fall-rise.
  function automatic mdl_t step(mdl_t mi, int n, bit r, bit e, bit x, int tmo);
    mdl_t m = mi;
    bit l, lp, ri, fa, fire;
    if (r) begin
      m.h = '0; m.armed = 0; m.t0 = n + 1; m.per = 0; m.hi = 0; m.v = 0; m.sh = 0; m.sl = 0;
      return m;
    end
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    l = maj(m.h[3], m.h[4], m.h[5]);
    lp = maj(m.h[4], m.h[5], m.h[6]);
`else
    l = m.h[2];
    lp = m.h[3];
`endif
    ri = l & !lp;
    fa = !l & lp;
    fire = 0;
    m.v = 0;
    if (!e) begin
      m.armed = 0; m.t0 = n + 1;
    end else if (!m.armed) begin
      if (ri) begin m.armed = 1; m.p = n; m.tf = -1; end
      else if (fa) m.t0 = n;
      else fire = (n - m.t0 >= tmo) && !m.sh && !m.sl;
    end else if (ri) begin
      if (m.tf >= 0) begin m.per = n - m.p; m.hi = m.tf - m.p; m.sh = 0; m.sl = 0; m.v = 1; end
      m.p = n; m.tf = -1;
    end else if (fa) begin
      if (m.tf < 0) m.tf = n;
    end else fire = n - m.p >= tmo;
    if (fire) begin
      m.per = 0; m.hi = 0; m.sh = l; m.sl = !l; m.v = 1; m.armed = 0; m.t0 = n + 1;
    end
    m.h = {m.h[6:0], x};
    return m;
  endfunction
  always @(posedge clk) begin
    ma = step(ma, cyc, rst, ena, pwm, 100);
    mb = step(mb, cyc, rst, ena, pwm, 65535);
    ena_s = ena;
    if (rst) started = 1'b1;
    cyc++;
  end
  task automatic chk(string nm, int per, int hi, bit v, bit sh, bit sl, mdl_t m);
    checks++;
    if (per != m.per || hi != m.hi || v != m.v || sh != m.sh || sl != m.sl) begin
      fails++;
      $display("FAIL %s cyc=%0d got per=%0d hi=%0d v=%0b sh=%0b sl=%0b expected per=%0d hi=%0d v=%0b sh=%0b sl=%0b",
               nm, cyc, per, hi, v, sh, sl, m.per, m.hi, m.v, m.sh, m.sl);
    end
  endtask
  task automatic pin(string nm, int got, int exp);
    checks++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
    end
  endtask
  always @(negedge clk) if (started) begin
    chk("dut_a", int'(ifa.period_cnt), int'(ifa.high_cnt), ifa.valid, ifa.stuck_high, ifa.stuck_low, ma);
    chk("dut_b", int'(ifb.period_cnt), int'(ifb.high_cnt), ifb.valid, ifb.stuck_high, ifb.stuck_low, mb);
    if (ifa.valid) va_cnt++;
    if (ifb.valid) begin
      vb_cnt++;
      b_prev = b_last;
      b_last = int'(ifb.period_cnt);
    end
    if (!ena_s && (ifa.valid || ifb.valid)) off_v++;
  end
  task automatic run(input int per, hi, n, off_at = -1, off_len = 0, glitch = -1);
    for (int t = 0; t < per * n; t++) begin
      pwm = ((t % per) < hi) ^ (t == glitch);
      ena = !(t >= off_at && t < off_at + off_len);
      @(negedge clk);
    end
    ena = 1'b1;
  endtask
  initial begin
    int v0;
    repeat (3) @(negedge clk);
    pin("reset_period", int'(ifb.period_cnt), 0);
    pin("reset_valid", int'(ifb.valid), 0);
    pin("reset_stuck", int'(ifa.stuck_high | ifa.stuck_low), 0);
    rst = 1'b0;
    run(20, 10, 8);
    pin("p20_b_period", int'(ifb.period_cnt), 20);
    pin("p20_b_high", int'(ifb.high_cnt), 10);
    pin("p20_a_period", int'(ifa.period_cnt), 20);
    run(256, 170, 4);
    pin("p256_period", int'(ifb.period_cnt), 256);
    pin("p256_high", int'(ifb.high_cnt), 170);
    pin("p256_stuck", int'(ifb.stuck_high | ifb.stuck_low), 0);
    run(20, 10, 3);
    pwm = 1'b1;
    repeat (10) @(negedge clk);
    v0 = va_cnt;
    repeat (240) @(negedge clk);
    pin("stuck_once", va_cnt - v0, 1);
    pin("stuck_high", int'(ifa.stuck_high), 1);
    pin("stuck_period", int'(ifa.period_cnt), 0);
    pin("stuck_high_cnt", int'(ifa.high_cnt), 0);
    run(20, 10, 4);
    pin("stuck_cleared", int'(ifa.stuck_high), 0);
    pin("resume_period", int'(ifa.period_cnt), 20);
    run(20, 10, 2);
    pwm = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pin("rst_period", int'(ifb.period_cnt), 0);
    pin("rst_high", int'(ifb.high_cnt), 0);
    pin("rst_valid", int'(ifb.valid), 0);
    v0 = vb_cnt;
    repeat (4) @(negedge clk);
    pwm = 1'b0;
    repeat (10) @(negedge clk);
    pin("rst_no_valid", vb_cnt - v0, 0);
    run(20, 10, 3);
    pin("rst_recover", int'(ifb.period_cnt), 20);
    v0 = vb_cnt;
    run(20, 10, 6, 25, 50);
    pin("ena_valids", vb_cnt - v0, 3);
    pin("ena_off_quiet", off_v, 0);
    pin("ena_period", int'(ifb.period_cnt), 20);
    pin("ena_high", int'(ifb.high_cnt), 10);
    run(20, 10, 3);
    run(20, 10, 1, -1, 0, 15);
    run(20, 10, 1);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    pin("glitch_last", b_last, 20);
    pin("glitch_prev", b_prev, 20);
    pin("glitch_high", int'(ifb.high_cnt), 10);
`else
    pin("glitch_last", b_last, 5);
    pin("glitch_prev", b_prev, 15);
    pin("glitch_high", int'(ifb.high_cnt), 1);
`endif
    for (int s = 0; s < 40; s++) begin
      int per, hi;
      per = $urandom_range(160, 4);
      hi = $urandom_range(per - 1, 1);
      if ($urandom_range(9, 0) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      if ($urandom_range(7, 0) == 0) begin
        pwm = 1'($urandom_range(1, 0));
        repeat ($urandom_range(200, 90)) @(negedge clk);
      end
      run(per, hi, $urandom_range(4, 1),
          $urandom_range(5, 0) == 0 ? $urandom_range(per, 0) : -1, $urandom_range(40, 1),
          $urandom_range(5, 0) == 0 ? $urandom_range(per - 1, 0) : -1);
    end
    repeat (10) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
